// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game sequencer: FSM, step timing, head motion, collisions, score
//
// Purpose:
//   Runs the IDLE/PLAY/EVAL/OVER game flow. Counts VGA frames to pace snake
//   steps, turns the snake right on button presses (at most one turn per
//   step), moves the head on the cell grid, detects wall and self collisions,
//   detects food and issues grow requests, and keeps a saturating score.
//
// Ports:
//   clk_25M        in   pixel clock
//   reset          in   synchronous, active-low
//   i_frame_start  in   one-cycle pulse at the start of each VGA frame
//   i_turn_right   in   raw turn button, active-high
//   i_start_btn    in   raw start button, active-high
//   i_food_col/row in   food cell position
//   i_self_hit     in   head overlaps a body segment (sampled in EVAL)
//   o_state        out  0=IDLE 1=PLAY 2=EVAL 3=OVER
//   o_head_col/row out  head cell position
//   o_dir          out  0=up 1=right 2=down 3=left
//   o_step         out  one-cycle pulse: head moved, body must shift
//   o_grow         out  one-cycle pulse: food eaten
//   o_score        out  binary score, saturating at MAX_SCORE
//   o_game_over    out  high in OVER
module snake_game_ctrl #(
  parameter int FRAMES_PER_STEP = 12,
  parameter int GRID_W          = 32,
  parameter int GRID_H          = 24,
  parameter int INIT_COL        = 13,
  parameter int INIT_ROW        = 11,
  parameter int MAX_SCORE       = 99
) (
  input  logic       clk_25M,
  input  logic       reset,
  input  logic       i_frame_start,
  input  logic       i_turn_right,
  input  logic       i_start_btn,
  input  logic [4:0] i_food_col,
  input  logic [4:0] i_food_row,
  input  logic       i_self_hit,
  output logic [1:0] o_state,
  output logic [4:0] o_head_col,
  output logic [4:0] o_head_row,
  output logic [1:0] o_dir,
  output logic       o_step,
  output logic       o_grow,
  output logic [6:0] o_score,
  output logic       o_game_over
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_EVAL = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam logic [4:0] COL_LAST  = 5'(GRID_W - 1);
  localparam logic [4:0] ROW_LAST  = 5'(GRID_H - 1);
  localparam logic [4:0] COL_INIT  = 5'(INIT_COL);
  localparam logic [4:0] ROW_INIT  = 5'(INIT_ROW);
  localparam logic [5:0] CNT_LAST  = 6'(FRAMES_PER_STEP - 1);
  localparam logic [6:0] SCORE_SAT = 7'(MAX_SCORE);

  state_t     r_state, w_state_nxt;
  logic [4:0] r_head_col, w_head_col_nxt;
  logic [4:0] r_head_row, w_head_row_nxt;
  logic [1:0] r_dir, w_dir_nxt;
  logic       r_step, w_step_nxt;
  logic       r_grow, w_grow_nxt;
  logic [6:0] r_score, w_score_nxt;
  logic [5:0] r_frame_cnt, w_frame_cnt_nxt;
  logic       r_pending, w_pending_nxt;

  // [0],[1] form the 2-FF synchronizer, [2] holds the previous synchronized
  // value for rising-edge detection.
  logic [2:0] r_turn_sync;
  logic [2:0] r_start_sync;

  logic       w_turn_edge;
  logic       w_start_edge;
  logic       w_step_due;
  logic [5:0] w_cnt_inc;
  logic [1:0] w_dir_next;
  logic [4:0] w_next_col;
  logic [4:0] w_next_row;
  logic       w_off_grid;

  assign w_turn_edge  = r_turn_sync[1] & ~r_turn_sync[2];
  assign w_start_edge = r_start_sync[1] & ~r_start_sync[2];
  assign w_step_due   = i_frame_start && (r_frame_cnt == CNT_LAST);
  assign w_cnt_inc    = (r_frame_cnt == CNT_LAST) ? 6'd0 : r_frame_cnt + 6'd1;
  // A turn edge landing on the move cycle still turns this step.
  assign w_dir_next   = r_dir + {1'b0, r_pending | w_turn_edge};

  // Synchronizers survive the OVER->IDLE restart; only reset clears them.
  always_ff @(posedge clk_25M) begin
    if (!reset) begin
      r_turn_sync  <= 3'b000;
      r_start_sync <= 3'b000;
    end else begin
      r_turn_sync  <= {r_turn_sync[1:0], i_turn_right};
      r_start_sync <= {r_start_sync[1:0], i_start_btn};
    end
  end

  // Candidate head cell for the upcoming move, plus wall check.
  always_comb begin
    w_next_col = r_head_col;
    w_next_row = r_head_row;
    w_off_grid = 1'b0;
    case (w_dir_next)
      2'd0: if (r_head_row == 5'd0)     w_off_grid = 1'b1; else w_next_row = r_head_row - 5'd1;
      2'd1: if (r_head_col == COL_LAST) w_off_grid = 1'b1; else w_next_col = r_head_col + 5'd1;
      2'd2: if (r_head_row == ROW_LAST) w_off_grid = 1'b1; else w_next_row = r_head_row + 5'd1;
      default: if (r_head_col == 5'd0)  w_off_grid = 1'b1; else w_next_col = r_head_col - 5'd1;
    endcase
  end

  always_ff @(posedge clk_25M) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_head_col  <= COL_INIT;
      r_head_row  <= ROW_INIT;
      r_dir       <= 2'd1;
      r_step      <= 1'b0;
      r_grow      <= 1'b0;
      r_score     <= 7'd0;
      r_frame_cnt <= 6'd0;
      r_pending   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_head_col  <= w_head_col_nxt;
      r_head_row  <= w_head_row_nxt;
      r_dir       <= w_dir_nxt;
      r_step      <= w_step_nxt;
      r_grow      <= w_grow_nxt;
      r_score     <= w_score_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_pending   <= w_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_head_col_nxt  = r_head_col;
    w_head_row_nxt  = r_head_row;
    w_dir_nxt       = r_dir;
    w_step_nxt      = 1'b0;
    w_grow_nxt      = 1'b0;
    w_score_nxt     = r_score;
    w_frame_cnt_nxt = r_frame_cnt;
    w_pending_nxt   = r_pending;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt     = S_PLAY;
          w_frame_cnt_nxt = 6'd0;
        end
      end
      S_PLAY: begin
        if (i_frame_start) w_frame_cnt_nxt = w_cnt_inc;
        if (w_step_due) begin
          if (w_off_grid) begin
            w_state_nxt = S_OVER;
          end else begin
            w_head_col_nxt = w_next_col;
            w_head_row_nxt = w_next_row;
            w_dir_nxt      = w_dir_next;
            w_pending_nxt  = 1'b0;
            w_step_nxt     = 1'b1;
            w_state_nxt    = S_EVAL;
          end
        end else if (w_turn_edge) begin
          w_pending_nxt = 1'b1;
        end
      end
      S_EVAL: begin
        if (i_frame_start) w_frame_cnt_nxt = w_cnt_inc;
        // Self-collision wins over food on the same step.
        if (i_self_hit) begin
          w_state_nxt = S_OVER;
        end else begin
          if ((r_head_col == i_food_col) && (r_head_row == i_food_row)) begin
            w_grow_nxt = 1'b1;
            if (r_score < SCORE_SAT) w_score_nxt = r_score + 7'd1;
          end
          w_state_nxt = S_PLAY;
        end
      end
      S_OVER: begin
        if (w_start_edge) begin
          w_state_nxt     = S_IDLE;
          w_head_col_nxt  = COL_INIT;
          w_head_row_nxt  = ROW_INIT;
          w_dir_nxt       = 2'd1;
          w_score_nxt     = 7'd0;
          w_frame_cnt_nxt = 6'd0;
          w_pending_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_state     = r_state;
  assign o_head_col  = r_head_col;
  assign o_head_row  = r_head_row;
  assign o_dir       = r_dir;
  assign o_step      = r_step;
  assign o_grow      = r_grow;
  assign o_score     = r_score;
  assign o_game_over = (r_state == S_OVER);

endmodule
